// File: rtl/txn_ingress_buffer_pkg.sv
// Shared types, default widths and the saturating counter helper for the
// transaction ingress buffer and its bench.
package txn_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // One single-beat bus transaction at the default widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] address;
    logic [DATA_W_DEF-1:0] data;
  } txn_t;

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/txn_ingress_buffer_if.sv
// Driver/consumer facing bundle of the ingress buffer: the offered
// transaction, the head-of-queue output handshake and the debug counters.
interface txn_ingress_buffer_if
  import txn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
);

  logic [ADDR_W-1:0]        address;
  logic [DATA_W-1:0]        data;
  logic                     valid;
  logic                     in_ready;
  logic [ADDR_W-1:0]        addr_out;
  logic [DATA_W-1:0]        data_out;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   level;
  logic [CNT_W-1:0]         drop_cnt;
  logic [CNT_W-1:0]         filt_cnt;

  // Stimulus driver / consumer side.
  modport master (
    output address, data, valid, out_ready,
    input  in_ready, addr_out, data_out, out_valid, level, drop_cnt, filt_cnt
  );

  // Buffer side.
  modport slave (
    input  address, data, valid, out_ready,
    output in_ready, addr_out, data_out, out_valid, level, drop_cnt, filt_cnt
  );

endinterface

// File: rtl/txn_ingress_buffer_fifo.sv
// Generic synchronous FIFO of packed entries with a registered head output.
// The head register holds the last popped entry once the FIFO drains, so the
// output never shows uninitialised storage.
module txn_fifo
  import txn_pkg::*;
#(
  parameter type T     = txn_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  T                       i_din,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level,
  output T                       o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  T               r_mem [DEPTH];
  T               r_head;
  T               w_head_nxt;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_level;
  logic [PW-1:0]  w_wr_nxt;
  logic [PW-1:0]  w_rd_nxt;
  logic [AW-1:0]  w_rd_idx_nx;
  logic           w_push_ok;
  logic           w_pop_ok;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_level;
  assign o_head  = r_head;

  // Qualify requests so the pointers can never over- or under-run.
  always_comb begin
    w_push_ok   = i_push && !o_full;
    w_pop_ok    = i_pop && !o_empty;
    w_wr_nxt    = r_wr_ptr + PW'(w_push_ok);
    w_rd_nxt    = r_rd_ptr + PW'(w_pop_ok);
    w_rd_idx_nx = r_rd_ptr[AW-1:0] + AW'(1);
  end

  // Pick what the head register shows after this edge: the next stored entry,
  // the entry being written when it becomes the head, or the current value.
  always_comb begin
    w_head_nxt = r_head;
    if (w_pop_ok) begin
      if (r_level > PW'(1)) begin
        w_head_nxt = r_mem[w_rd_idx_nx];
      end else if (w_push_ok) begin
        w_head_nxt = i_din;
      end
    end else if (w_push_ok && o_empty) begin
      w_head_nxt = i_din;
    end
  end

  // Pointers, occupancy and head register; reset discards all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_wr_nxt - w_rd_nxt;
      r_head   <= w_head_nxt;
    end
  end

  // Entry storage is not reset; only slots behind the write pointer are read.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

endmodule

// File: rtl/txn_ingress_buffer.sv
// Ingress buffer: accepts transactions whose address falls in the configured
// window, queues them in order, and counts refused and out-of-window offers.
module txn_ingress_buffer
  import txn_pkg::*;
#(
  parameter int               ADDR_W     = ADDR_W_DEF,
  parameter int               DATA_W     = DATA_W_DEF,
  parameter int               DEPTH      = 4,
  parameter logic [ADDR_W-1:0] ADDR_MASK = 8'hF0,
  parameter logic [ADDR_W-1:0] ADDR_MATCH = 8'hA0,
  parameter int               CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  txn_ingress_buffer_if.slave  bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              w_din;
  ent_t              w_head;
  logic              w_match;
  logic              w_full;
  logic              w_empty;
  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_filt;
  logic [LW-1:0]     w_level;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [CNT_W-1:0]  r_filt_cnt;

  // Ready depends only on registered occupancy, never on out_ready.
  always_comb begin
    w_match       = ((bus.address & ADDR_MASK) == ADDR_MATCH);
    w_in_ready    = !w_full;
    w_push        = bus.valid && w_match && w_in_ready;
    w_pop         = !w_empty && bus.out_ready;
    w_drop        = bus.valid && w_match && !w_in_ready;
    w_filt        = bus.valid && !w_match;
    w_din.address = bus.address;
    w_din.data    = bus.data;
  end

  txn_fifo #(
    .T     (ent_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level),
    .o_head  (w_head)
  );

  // Count in-window offers refused because the buffer was full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= CNT_W'(sat_inc(32'(r_drop_cnt), CNT_W));
    end
  end

  // Count out-of-window offers; these are never stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_cnt <= '0;
    end else if (w_filt) begin
      r_filt_cnt <= CNT_W'(sat_inc(32'(r_filt_cnt), CNT_W));
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = !w_empty;
  assign bus.addr_out  = w_head.address;
  assign bus.data_out  = w_head.data;
  assign bus.level     = w_level;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.filt_cnt  = r_filt_cnt;

endmodule

// File: tb/tb_txn_ingress_buffer.sv
// Bench for txn_ingress_buffer: directed scenarios plus a randomized run,
// all checked against a queue-based model of the buffer's rules.
module tb_txn_ingress_buffer;
  import txn_pkg::*;

  localparam int         ADDR_W  = 8;
  localparam int         DATA_W  = 8;
  localparam int         DEPTH   = 4;
  localparam int         CNT_W   = 8;
  localparam logic [7:0] MASK    = 8'hF0;
  localparam logic [7:0] MATCH   = 8'hA0;
  localparam int         CNT_MAX = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  txn_ingress_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  txn_ingress_buffer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .ADDR_MASK(MASK), .ADDR_MATCH(MATCH), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;

  txn_t mq[$];
  int   m_drop;
  int   m_filt;
  txn_t m_last;

  task automatic model_reset();
    mq.delete();
    m_drop = 0;
    m_filt = 0;
    m_last = '0;
  endtask

  // Drive one cycle of inputs, advance one edge, apply the rules to the model.
  task automatic cycle(input logic [7:0] a, input logic [7:0] d, input logic v, input logic r);
    bit   m, rdy;
    txn_t t;
    bus.address = a; bus.data = d; bus.valid = v; bus.out_ready = r;
    @(posedge clk);
    m   = ((a & MASK) == MATCH);
    rdy = (mq.size() < DEPTH);
    if (v && !m && m_filt < CNT_MAX) m_filt++;
    if (v && m && !rdy && m_drop < CNT_MAX) m_drop++;
    if (r && mq.size() > 0) m_last = mq.pop_front();
    if (v && m && rdy) begin t.address = a; t.data = d; mq.push_back(t); end
    #1;
  endtask

  task automatic hard_reset();
    bus.address = '0; bus.data = '0; bus.valid = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    hard_reset();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0h expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0h expected 1", bus.in_ready); end
    checks++; if (bus.level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0h expected 0", bus.level); end
    checks++; if (bus.addr_out !== 8'h00) begin failures++; $display("FAIL reset_addr_out: got %0h expected 0", bus.addr_out); end
    checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out: got %0h expected 0", bus.data_out); end
    checks++; if (bus.drop_cnt !== 8'h00) begin failures++; $display("FAIL reset_drop_cnt: got %0h expected 0", bus.drop_cnt); end
    checks++; if (bus.filt_cnt !== 8'h00) begin failures++; $display("FAIL reset_filt_cnt: got %0h expected 0", bus.filt_cnt); end
  endtask

  task automatic test_single();
    cycle(8'hAA, 8'h55, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid: got %0h expected 1", bus.out_valid); end
    checks++; if (bus.addr_out !== 8'hAA) begin failures++; $display("FAIL single_addr_out: got %0h expected aa", bus.addr_out); end
    checks++; if (bus.data_out !== 8'h55) begin failures++; $display("FAIL single_data_out: got %0h expected 55", bus.data_out); end
    checks++; if (bus.level !== 3'd1) begin failures++; $display("FAIL single_level: got %0h expected 1", bus.level); end
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== 8'h55 || bus.addr_out !== 8'hAA) begin
        failures++; $display("FAIL single_hold: got v=%0h a=%0h d=%0h expected v=1 a=aa d=55", bus.out_valid, bus.addr_out, bus.data_out);
      end
    end
    cycle(8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid: got %0h expected 0", bus.out_valid); end
    checks++; if (bus.level !== 3'd0) begin failures++; $display("FAIL single_pop_level: got %0h expected 0", bus.level); end
    checks++; if (bus.data_out !== 8'h55) begin failures++; $display("FAIL single_last_popped: got %0h expected 55", bus.data_out); end
  endtask

  task automatic test_fill_drop();
    hard_reset();
    for (int i = 0; i < 4; i++) cycle(8'hA0 + 8'(i), 8'h01 + 8'(i), 1'b1, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready: got %0h expected 0", bus.in_ready); end
    cycle(8'hA4, 8'h05, 1'b1, 1'b0);
    checks++; if (bus.level !== 3'd4) begin failures++; $display("FAIL full_level: got %0h expected 4", bus.level); end
    checks++; if (bus.drop_cnt !== 8'd1) begin failures++; $display("FAIL full_drop_cnt: got %0h expected 1", bus.drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== 8'h01 + 8'(i)) begin
        failures++; $display("FAIL drain_order: got v=%0h d=%0h expected v=1 d=%0h", bus.out_valid, bus.data_out, 8'h01 + 8'(i));
      end
      cycle(8'h00, 8'h00, 1'b0, 1'b1);
    end
    checks++; if (bus.level !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty: got l=%0h v=%0h expected l=0 v=0", bus.level, bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    hard_reset();
    cycle(8'hA1, 8'h0B, 1'b1, 1'b0);
    cycle(8'hA2, 8'h0C, 1'b1, 1'b0);
    cycle(8'hA5, 8'h10, 1'b1, 1'b1);
    checks++; if (bus.level !== 3'd2) begin failures++; $display("FAIL b2b_level: got %0h expected 2", bus.level); end
    checks++; if (bus.data_out !== 8'h0C) begin failures++; $display("FAIL b2b_head: got %0h expected 0c", bus.data_out); end
    cycle(8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (bus.data_out !== 8'h10 || bus.addr_out !== 8'hA5) begin failures++; $display("FAIL b2b_third: got a=%0h d=%0h expected a=a5 d=10", bus.addr_out, bus.data_out); end
    cycle(8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (bus.level !== 3'd0) begin failures++; $display("FAIL b2b_drained: got %0h expected 0", bus.level); end
  endtask

  task automatic test_filter();
    logic [3:0] n;
    hard_reset();
    cycle(8'h3C, 8'h77, 1'b1, 1'b0);
    checks++; if (bus.level !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL filt_not_stored: got l=%0h v=%0h expected l=0 v=0", bus.level, bus.out_valid); end
    checks++; if (bus.filt_cnt !== 8'd1) begin failures++; $display("FAIL filt_cnt_one: got %0h expected 1", bus.filt_cnt); end
    for (int i = 0; i < 299; i++) begin
      do n = 4'($urandom_range(0, 15)); while (n == 4'hA);
      cycle({n, 4'($urandom_range(0, 15))}, 8'($urandom), 1'b1, 1'($urandom_range(0, 1)));
    end
    checks++; if (bus.filt_cnt !== 8'hFF) begin failures++; $display("FAIL filt_cnt_sat: got %0h expected ff", bus.filt_cnt); end
    checks++; if (bus.level !== 3'd0 || bus.drop_cnt !== 8'd0) begin failures++; $display("FAIL filt_side_effect: got l=%0h drop=%0h expected 0 0", bus.level, bus.drop_cnt); end
  endtask

  task automatic test_reset_mid();
    hard_reset();
    cycle(8'hA7, 8'h31, 1'b1, 1'b0);
    cycle(8'h3C, 8'h99, 1'b1, 1'b0);
    cycle(8'hA8, 8'h32, 1'b1, 1'b0);
    cycle(8'hA9, 8'h33, 1'b1, 1'b0);
    checks++; if (bus.level !== 3'd3 || bus.filt_cnt !== 8'd1) begin failures++; $display("FAIL mid_prefill: got l=%0h f=%0h expected l=3 f=1", bus.level, bus.filt_cnt); end
    bus.valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin failures++; $display("FAIL mid_rst_state: got v=%0h l=%0h expected 0 0", bus.out_valid, bus.level); end
    checks++; if (bus.data_out !== 8'h00 || bus.addr_out !== 8'h00) begin failures++; $display("FAIL mid_rst_head: got a=%0h d=%0h expected 0 0", bus.addr_out, bus.data_out); end
    checks++; if (bus.drop_cnt !== 8'd0 || bus.filt_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_rst_ctrl: got drop=%0h filt=%0h rdy=%0h expected 0 0 1", bus.drop_cnt, bus.filt_cnt, bus.in_ready);
    end
    model_reset();
    #8;
    rst_n = 1'b1;
    test_single();
  endtask

  task automatic test_full_pop();
    hard_reset();
    for (int i = 0; i < 4; i++) cycle(8'hA0 + 8'(i), 8'h11 + 8'(i), 1'b1, 1'b0);
    cycle(8'hA6, 8'h20, 1'b1, 1'b1);
    checks++; if (bus.level !== 3'd3) begin failures++; $display("FAIL fullpop_level: got %0h expected 3", bus.level); end
    checks++; if (bus.drop_cnt !== 8'd1) begin failures++; $display("FAIL fullpop_drop: got %0h expected 1", bus.drop_cnt); end
    checks++; if (bus.data_out !== 8'h12 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL fullpop_head: got d=%0h rdy=%0h expected d=12 rdy=1", bus.data_out, bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.data_out !== 8'h12 + 8'(i)) begin failures++; $display("FAIL fullpop_order: got %0h expected %0h", bus.data_out, 8'h12 + 8'(i)); end
      cycle(8'h00, 8'h00, 1'b0, 1'b1);
    end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fullpop_refused_gone: got %0h expected 0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [7:0] a;
    txn_t       eh;
    hard_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) != 0) a = {4'hA, 4'($urandom_range(0, 15))};
      else a = 8'($urandom);
      cycle(a, 8'($urandom), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      eh = (mq.size() > 0) ? mq[0] : m_last;
      checks++; if (bus.out_valid !== (mq.size() > 0) || bus.level !== 3'(mq.size()) || bus.in_ready !== (mq.size() < DEPTH)) begin
        failures++; $display("FAIL rand_state cyc %0d: got v=%0h l=%0h r=%0h expected l=%0d", i, bus.out_valid, bus.level, bus.in_ready, mq.size());
      end
      checks++; if (bus.addr_out !== eh.address || bus.data_out !== eh.data) begin
        failures++; $display("FAIL rand_head cyc %0d: got a=%0h d=%0h expected a=%0h d=%0h", i, bus.addr_out, bus.data_out, eh.address, eh.data);
      end
      checks++; if (bus.drop_cnt !== 8'(m_drop) || bus.filt_cnt !== 8'(m_filt)) begin
        failures++; $display("FAIL rand_cnt cyc %0d: got drop=%0h filt=%0h expected drop=%0h filt=%0h", i, bus.drop_cnt, bus.filt_cnt, m_drop, m_filt);
      end
    end
  endtask

  initial begin
    bus.address = '0; bus.data = '0; bus.valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_fill_drop();
    test_back_to_back();
    test_filter();
    test_reset_mid();
    test_full_pop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/txn_ingress_buffer.md
Name: txn_ingress_buffer

Overview:
- Receives single-beat address/data bus transactions and buffers them in a small FIFO.
- Presents the oldest buffered transaction on a valid/ready output with `data_out`. This output is the observation point the monitor and scoreboard sample.
- Sits directly downstream of the stimulus driver, between the driver-facing interface and the checker side.
- Also filters transactions by address window and counts dropped and filtered transactions for coverage and debug.

Parameters:
- ADDR_W, 8, address width in bits
- DATA_W, 8, data width in bits
- DEPTH, 4, FIFO entries; power of two, minimum 2
- ADDR_MASK, 8'hF0, address bits compared for acceptance
- ADDR_MATCH, 8'hA0, required value of (address & ADDR_MASK)
- CNT_W, 8, width of the drop and filter counters

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- address  input  ADDR_W  transaction address
- data  input  DATA_W  transaction data
- valid  input  1  transaction offered this cycle
- in_ready  output  1  buffer can accept; equals !full
- addr_out  output  ADDR_W  address at the FIFO head
- data_out  output  DATA_W  data at the FIFO head
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer takes the head entry this cycle
- level  output  $clog2(DEPTH)+1  current occupancy
- drop_cnt  output  CNT_W  count of valid && address match && !in_ready; saturates at all-ones
- filt_cnt  output  CNT_W  count of valid && address mismatch; saturates at all-ones

Behaviour:
- Reset (asynchronous, rst_n low): pointers = 0, level = 0, out_valid = 0, in_ready = 1, addr_out = 0, data_out = 0, drop_cnt = 0, filt_cnt = 0. Storage contents are not reset.
- Reset asserted mid-operation: all buffered entries are discarded immediately; no partial output.
- match = ((address & ADDR_MASK) == ADDR_MATCH).
- push = valid && match && in_ready.
- pop = out_valid && out_ready.
- Latency: a transaction pushed on edge N appears on addr_out/data_out with out_valid=1 after edge N, when the FIFO was empty. Pass-through is never combinational.
- Ordering: output order strictly equals push order.
- Head outputs: addr_out/data_out are driven from the head entry. When empty they hold the last popped value (0 after reset). The consumer must ignore them while out_valid=0.
- out_valid holds with stable head data until pop. The consumer may keep out_ready high continuously.
- Simultaneous push and pop, 0 < level < DEPTH: level unchanged, both pointers advance.
- Simultaneous push and pop, level == DEPTH: push is refused because in_ready=0. The pop still occurs, so level becomes DEPTH-1. Ready never depends combinationally on out_ready.
- Push at level == 0: out_valid is 1 from the next cycle.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. full = (MSBs differ && LSBs equal); empty = (pointers equal).
- Counters:
  - drop_cnt increments when valid && match && !in_ready.
  - filt_cnt increments when valid && !match, regardless of in_ready.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Mismatched transactions are never stored.
- level = wr_ptr - rd_ptr, registered with the pointers.

Decomposition:
- Package txn_pkg:
  - ADDR_W_DEF, DATA_W_DEF constants.
  - typedef struct packed { logic [ADDR_W-1:0] address; logic [DATA_W-1:0] data; } txn_t, shared with the bench's transaction class.
  - Function sat_inc() for the saturating counters.
- Sub-module txn_fifo:
  - Generic txn_t FIFO with push/pop/full/empty/level.
  - The top block adds the address filter, handshake mapping and counters.

Test Plan:
- Reset, then address=8'hAA, data=8'h55, valid=1 for one cycle, out_ready=0 -> next cycle out_valid=1, addr_out=8'hAA, data_out=8'h55, level=1; these hold until out_ready=1, then out_valid=0 and level=0.
- Push 8'hA0/8'h01 through 8'hA3/8'h04 with out_ready=0, then offer 8'hA4/8'h05 -> in_ready=0, level=4, drop_cnt=1; draining yields data 01,02,03,04 in order.
- With level=2, assert valid (8'hA5/8'h10) and out_ready in the same cycle -> level stays 2, head advances, 8'h10 emerges third.
- Offer address=8'h3C, data=8'h77 -> not stored, level unchanged, filt_cnt=1; after 300 mismatched offers filt_cnt=8'hFF.
- Fill to level=3, assert rst_n=0 mid-cycle -> out_valid=0, level=0, data_out=0, counters=0 immediately without waiting for a clock edge; after release, a push of 8'hAA/8'h55 behaves as in the first scenario.
- At level=4 with out_ready=1 and valid=1 (8'hA6/8'h20) -> pop occurs, push refused, level=3, drop_cnt increments by 1.
